// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, the NOP encoding, fetch FSM states and
// the IF/ID pipeline register payload.
package cpu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [0:0] {BOOT, RUN} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [ILEN-1:0] instr;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/fulladd_64.sv
// 64-bit adder/subtractor shared with the single-cycle datapath.
// Ports:
//   a_i, b_i    operands
//   sub_flag_i  0: a+b, 1: a-b (two's complement)
//   sum_o       result, modulo 2^64
module fulladd_64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        sub_flag_i,
  output logic [63:0] sum_o
);

  assign sum_o = a_i + (b_i ^ {64{sub_flag_i}}) + {63'd0, sub_flag_i};

endmodule

// File: rtl/ifid_reg.sv
// Generic pipeline stage register carrying an ifid_t payload.
// Ports:
//   clk       clock
//   rst_n     async active-low clear to the bubble value
//   load_i    capture d_i
//   bubble_i  capture the bubble value (wins over load_i)
//   d_i       incoming payload
//   q_o       registered payload
// With neither load_i nor bubble_i the contents hold.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  bubble_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= IFID_BUBBLE;
    end else if (bubble_i) begin
      q_o <= IFID_BUBBLE;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills
// the IF/ID register. Handles stall/flush from the hazard unit and taken
// branch redirects resolved in ID.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   stall, flush            hazard unit controls
//   br_taken, br_target     redirect from ID
//   imem_addr / imem_instr  instruction memory interface (addr is the PC reg)
//   ifid_*                  IF/ID register contents
//   fetch_count             saturating count of valid instructions latched
//   bubble_count            saturating count of flush/redirect bubbles
//
// state | meaning
// BOOT  | first cycle after reset release, PC held, nothing latched
// RUN   | normal fetch with br_taken > stall > flush > normal priority
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   fetch_count,
  output logic [CNT_W-1:0]   bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic              ifid_load;
  logic              ifid_bubble;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  fulladd_64 u_pc_inc (
    .a_i        (pc_q),
    .b_i        (64'd4),
    .sub_flag_i (1'b0),
    .sum_o      (pc_plus4)
  );

  // IF/ID control; BOOT leaves the register untouched.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (state_q == RUN) begin
      if (br_taken)     ifid_bubble = 1'b1;
      else if (stall)   ifid_bubble = 1'b0;
      else if (flush)   ifid_bubble = 1'b1;
      else              ifid_load   = 1'b1;
    end
  end

  assign ifid_d = '{pc: pc_q, pc4: pc_plus4, instr: imem_instr, valid: 1'b1};

  ifid_reg u_ifid (
    .clk      (clk),
    .rst_n    (reset_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (br_taken) begin
            // Targets are word aligned; drop any stray low bits.
            pc_q <= br_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
            if (~&bubble_cnt_q) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (flush) begin
            pc_q <= pc_plus4;
            if (~&bubble_cnt_q) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
          end else begin
            pc_q <= pc_plus4;
            if (~&fetch_cnt_q) fetch_cnt_q <= fetch_cnt_q + CNT_ONE;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_pc      = ifid_q.pc;
  assign ifid_pc4     = ifid_q.pc4;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_valid   = ifid_q.valid;
  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] ifid_pc, ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_count, bubble_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [63:0] a);
    return a[31:0] ^ 32'h91000421 ^ {a[63:32]};
  endfunction

  assign imem_instr = imem_fn(imem_addr);

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] bc;
  } snap_t;

  snap_t exp_q[$];

  // Reference model: what the stage should hold after each clock edge.
  logic        m_boot;
  snap_t       m;

  function automatic logic [31:0] sat1(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m.addr = 64'h0; m.pc = 64'h0; m.pc4 = 64'h0;
    m.instr = NOP; m.valid = 1'b0; m.fc = 0; m.bc = 0;
  endtask

  task automatic model_edge();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (br_taken) begin
      m.valid = 1'b0; m.instr = NOP;
      m.addr = {br_target[63:2], 2'b00};
      m.bc = sat1(m.bc);
    end else if (stall) begin
      // nothing moves
    end else if (flush) begin
      m.valid = 1'b0; m.instr = NOP;
      m.addr = m.addr + 64'd4;
      m.bc = sat1(m.bc);
    end else begin
      m.pc = m.addr; m.pc4 = m.addr + 64'd4;
      m.instr = imem_fn(m.addr); m.valid = 1'b1;
      m.addr = m.addr + 64'd4;
      m.fc = sat1(m.fc);
    end
  endtask

  // Called at a negedge: drive inputs, predict the next edge, advance to next negedge.
  task automatic step(input logic b, input logic [63:0] t, input logic s, input logic f);
    br_taken = b; br_target = t; stall = s; flush = f;
    model_edge();
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " imem_addr"}, imem_addr, 64'h0);
    chk({tag, " ifid_pc"}, ifid_pc, 64'h0);
    chk({tag, " ifid_pc4"}, ifid_pc4, 64'h0);
    chk({tag, " ifid_instr"}, {32'h0, ifid_instr}, {32'h0, NOP});
    chk({tag, " ifid_valid"}, {63'h0, ifid_valid}, 64'h0);
    chk({tag, " fetch_count"}, {32'h0, fetch_count}, 64'h0);
    chk({tag, " bubble_count"}, {32'h0, bubble_count}, 64'h0);
  endtask

  // Monitor: the DUT presents a new IF/ID snapshot after every edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (imem_addr !== e.addr || ifid_valid !== e.valid || ifid_instr !== e.instr ||
            fetch_count !== e.fc || bubble_count !== e.bc ||
            (e.valid && (ifid_pc !== e.pc || ifid_pc4 !== e.pc4))) begin
          miscompares++;
          $display("FAIL scoreboard @%0t: got addr=%0h pc=%0h pc4=%0h instr=%0h v=%0b fc=%0d bc=%0d expected addr=%0h pc=%0h pc4=%0h instr=%0h v=%0b fc=%0d bc=%0d",
                   $time, imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid, fetch_count, bubble_count,
                   e.addr, e.pc, e.pc4, e.instr, e.valid, e.fc, e.bc);
        end
      end
    end
  end

  initial begin
    logic [63:0] hold_pc;
    logic [31:0] hold_fc, hold_bc;
    model_reset();
    @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;

    // BOOT then three fetches
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("t1 ifid_pc", ifid_pc, 64'h8);
    chk("t1 fetch_count", {32'h0, fetch_count}, 64'd3);
    chk("t1 valid", {63'h0, ifid_valid}, 64'd1);

    // advance to pc 0x10, then redirect to 0x40
    step(0, 0, 0, 0);
    chk("t2 pre pc", imem_addr, 64'h10);
    step(1, 64'h40, 0, 0);
    chk("t2 valid", {63'h0, ifid_valid}, 64'd0);
    chk("t2 pc", imem_addr, 64'h40);
    step(0, 0, 0, 0);
    chk("t2 ifid_pc", ifid_pc, 64'h40);
    chk("t2 bubble_count", {32'h0, bubble_count}, 64'd1);

    // stall for three cycles at 0x20
    step(1, 64'h20, 0, 0);
    step(0, 0, 0, 0);
    step(1, 64'h20, 0, 0);
    hold_pc = ifid_pc; hold_fc = fetch_count; hold_bc = bubble_count;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, i[0]);
      chk("t3 addr held", imem_addr, 64'h20);
      chk("t3 ifid_pc held", ifid_pc, hold_pc);
      chk("t3 counts held", {fetch_count, bubble_count}, {hold_fc, hold_bc});
    end
    step(0, 0, 0, 0);
    chk("t3 resume ifid_pc", ifid_pc, 64'h20);
    chk("t3 resume addr", imem_addr, 64'h24);

    // everything at once: redirect wins, low bits dropped
    hold_bc = bubble_count;
    step(1, 64'h103, 1, 1);
    chk("t4 pc", imem_addr, 64'h100);
    chk("t4 valid", {63'h0, ifid_valid}, 64'd0);
    chk("t4 bubble_count", {32'h0, bubble_count}, {32'h0, hold_bc + 32'd1});

    // wrap at top of address space
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    step(0, 0, 0, 0);
    chk("t5 pc wrap", imem_addr, 64'h0);
    chk("t5 ifid_pc4 wrap", ifid_pc4, 64'h0);
    chk("t5 ifid_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic b, s, f;
      logic [63:0] t;
      b = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 7) == 0);
      t = {$urandom, $urandom};
      step(b, t, s, f);
    end

    // async reset in the middle of a redirect cycle
    br_taken = 1'b1; br_target = 64'h1234_5678_9ABC_DEF0;
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("async reset");
    exp_q.delete();
    model_reset();
    exp_q.push_back(m);
    br_taken = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(0, 9) == 0), {$urandom, $urandom},
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end
    step(0, 0, 0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
